painterengine_gpu_blitter: RTL and testbench
============================================

Name: painterengine_gpu_blitter

Overview:
- Parametrised successor to the GPU renderer tile sequencer.
- Walks a rectangular region row by row in chunks of up to BLOCK_PIXELS pixels. For each chunk it drives the external reader and writer controllers.
- Supports three modes: COPY (src→dst), BLEND (src+dst→dst) and FILL (write only).
- Adds a start/busy/done handshake, independent source and destination strides, and zero-size handling. Sits between the AXI-lite register file and the reader/writer/FIFO blocks.

Parameters:
- BLOCK_PIXELS, 8, maximum pixels per chunk (≥1).
- ADDR_WIDTH, 32, width of address, stride and count signals.
- BYTES_PER_PIXEL, 4, byte stride per pixel.

Ports:
- i_wire_clock  in  1  sole clock.
- i_wire_reset  in  1  reset, asynchronous, active-high.
- i_wire_start  in  1  one-cycle start pulse; sampled only in IDLE or DONE.
- i_wire_mode  in  2  00 COPY, 01 BLEND, 10 FILL, 11 reserved.
- i_wire_src_frame_buffer_address  in  ADDR_WIDTH  source base address.
- i_wire_dst_frame_buffer_address  in  ADDR_WIDTH  destination base address.
- i_wire_src_frame_buffer_width  in  ADDR_WIDTH  source stride in pixels.
- i_wire_dst_frame_buffer_width  in  ADDR_WIDTH  destination stride in pixels.
- i_wire_render_frame_buffer_xcount  in  ADDR_WIDTH  region width in pixels.
- i_wire_render_frame_buffer_ycount  in  ADDR_WIDTH  region height in rows.
- o_wire_reader_address  out  ADDR_WIDTH  reader byte address.
- o_wire_reader_length  out  ADDR_WIDTH  reader length in pixels.
- o_wire_reader1_resetn  out  1  enables reader into FIFO1 (source).
- o_wire_reader2_resetn  out  1  enables reader into FIFO2 (destination).
- i_wire_reader_done  in  1  reader completion.
- i_wire_reader_error  in  1  reader error.
- o_wire_writer_address  out  ADDR_WIDTH  writer byte address.
- o_wire_writer_length  out  ADDR_WIDTH  writer length in pixels.
- o_wire_writer_resetn  out  1  enables writer.
- i_wire_writer_done  in  1  writer completion.
- i_wire_writer_error  in  1  writer error.
- o_wire_fifo1_resetn  out  1  FIFO1 reset release.
- o_wire_fifo2_resetn  out  1  FIFO2 reset release.
- o_wire_busy  out  1  high outside IDLE, DONE and ERROR.
- o_wire_done  out  1  high while in DONE.
- o_wire_error  out  1  high while in ERROR.
- o_wire_state  out  32  zero-extended 8-bit state code.

Behaviour:
- Reset: all outputs 0, state IDLE, internal x/y/config registers 0.
- State codes: IDLE 0x00, CALC 0x01, READ1 0x02, READ2 0x03, WRITE 0x04, DONE 0x05, ERROR 0x06.
- IDLE/DONE + start:
  - Latch all config inputs; later input changes are ignored until the next start.
  - Clear x and y; drive both fifo resetn high.
  - mode==11 → ERROR.
  - xcount==0 or ycount==0 → DONE.
  - Otherwise → CALC.
- In IDLE and after reset, fifo resetn outputs are 0. They stay 1 from start until reset.
- CALC (exactly one cycle per chunk or row wrap):
  - len = min(BLOCK_PIXELS, xcount−x).
  - If x==xcount:
    - y+1==ycount → DONE.
    - Otherwise x←0, y←y+1, stay in CALC.
  - Else by mode:
    - COPY/BLEND: reader_address←src+(y·src_width+x)·BYTES_PER_PIXEL, reader_length←len, reader1_resetn←1, → READ1.
    - FILL: writer_address/length loaded (see WRITE), writer_resetn←1, → WRITE.
- READ1:
  - Error input high → ERROR.
  - Else on reader_done: reader1_resetn←0.
    - BLEND: reader_address←dst+(y·dst_width+x)·BYTES_PER_PIXEL, reader2_resetn←1, → READ2.
    - COPY: load writer, writer_resetn←1, → WRITE.
- READ2:
  - Error → ERROR.
  - On done: reader2_resetn←0, load writer, writer_resetn←1, → WRITE.
- Writer load:
  - writer_address←dst+(y·dst_width+x)·BYTES_PER_PIXEL.
  - writer_length←len.
- WRITE:
  - Error → ERROR.
  - On writer_done: writer_resetn←0, x←x+len, → CALC.
- Each enable is high for the full duration of its state, asserted on the entry edge. At most one of reader1, reader2 and writer enables is high at any time.
- done and error inputs asserted in the same cycle: error wins.
- done/error inputs are ignored in IDLE, CALC, DONE and ERROR.
- Arithmetic is unsigned, truncated to ADDR_WIDTH; address wrap is not flagged.
- ERROR is sticky; only reset leaves it, and start is ignored there.
- DONE holds until start, which restarts.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous) and drops all enables.

Test Plan:
- COPY, xcount=20, ycount=2, src=0x1000, dst=0x8000, src_width=dst_width=32, BLOCK_PIXELS=8 → reader lengths 8,8,4 per row; row-1 chunk 0 reader address 0x1080; 6 writes; DONE asserted.
- BLEND, xcount=5, ycount=1, src_width=64, dst_width=16, y=0 → READ1 at src, READ2 at dst, write at dst, all length 5; sequence of state codes 1,2,3,4,1,5.
- FILL, xcount=9, ycount=3 → no reader enable ever high; writer lengths 8,1 per row; addresses use dst_width.
- Zero size: xcount=0, start → DONE next cycle, no enables. mode=11 → ERROR, o_wire_error=1; subsequent start ignored.
- Error handling: reader_error together with reader_done in READ1 → ERROR. Reset asserted mid-WRITE → all outputs 0 same cycle, state IDLE.
- Config change after start (xcount 16→4) → chunk count unchanged (2 per row).

Source files
------------

// File: rtl/painterengine_gpu_blitter_if.sv
// Control bundle between the register file, the blitter and the
// reader/writer/FIFO blocks.
interface painterengine_gpu_blitter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_wire_start;
  logic [1:0]            i_wire_mode;
  logic [ADDR_WIDTH-1:0] i_wire_src_frame_buffer_address;
  logic [ADDR_WIDTH-1:0] i_wire_dst_frame_buffer_address;
  logic [ADDR_WIDTH-1:0] i_wire_src_frame_buffer_width;
  logic [ADDR_WIDTH-1:0] i_wire_dst_frame_buffer_width;
  logic [ADDR_WIDTH-1:0] i_wire_render_frame_buffer_xcount;
  logic [ADDR_WIDTH-1:0] i_wire_render_frame_buffer_ycount;
  logic [ADDR_WIDTH-1:0] o_wire_reader_address;
  logic [ADDR_WIDTH-1:0] o_wire_reader_length;
  logic                  o_wire_reader1_resetn;
  logic                  o_wire_reader2_resetn;
  logic                  i_wire_reader_done;
  logic                  i_wire_reader_error;
  logic [ADDR_WIDTH-1:0] o_wire_writer_address;
  logic [ADDR_WIDTH-1:0] o_wire_writer_length;
  logic                  o_wire_writer_resetn;
  logic                  i_wire_writer_done;
  logic                  i_wire_writer_error;
  logic                  o_wire_fifo1_resetn;
  logic                  o_wire_fifo2_resetn;
  logic                  o_wire_busy;
  logic                  o_wire_done;
  logic                  o_wire_error;
  logic [31:0]           o_wire_state;

  modport master (
    input  i_wire_start, i_wire_mode,
    input  i_wire_src_frame_buffer_address,
    input  i_wire_dst_frame_buffer_address,
    input  i_wire_src_frame_buffer_width,
    input  i_wire_dst_frame_buffer_width,
    input  i_wire_render_frame_buffer_xcount,
    input  i_wire_render_frame_buffer_ycount,
    input  i_wire_reader_done, i_wire_reader_error,
    input  i_wire_writer_done, i_wire_writer_error,
    output o_wire_reader_address, o_wire_reader_length,
    output o_wire_reader1_resetn, o_wire_reader2_resetn,
    output o_wire_writer_address, o_wire_writer_length,
    output o_wire_writer_resetn,
    output o_wire_fifo1_resetn, o_wire_fifo2_resetn,
    output o_wire_busy, o_wire_done, o_wire_error,
    output o_wire_state
  );

  modport slave (
    output i_wire_start, i_wire_mode,
    output i_wire_src_frame_buffer_address,
    output i_wire_dst_frame_buffer_address,
    output i_wire_src_frame_buffer_width,
    output i_wire_dst_frame_buffer_width,
    output i_wire_render_frame_buffer_xcount,
    output i_wire_render_frame_buffer_ycount,
    output i_wire_reader_done, i_wire_reader_error,
    output i_wire_writer_done, i_wire_writer_error,
    input  o_wire_reader_address, o_wire_reader_length,
    input  o_wire_reader1_resetn, o_wire_reader2_resetn,
    input  o_wire_writer_address, o_wire_writer_length,
    input  o_wire_writer_resetn,
    input  o_wire_fifo1_resetn, o_wire_fifo2_resetn,
    input  o_wire_busy, o_wire_done, o_wire_error,
    input  o_wire_state
  );
endinterface

// File: rtl/painterengine_gpu_blitter.sv
// Region blitter: walks a rectangle in chunks and sequences the
// reader/writer controllers for COPY, BLEND and FILL.
module painterengine_gpu_blitter #(
  parameter int BLOCK_PIXELS    = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int BYTES_PER_PIXEL = 4
) (
  input logic i_wire_clock,
  input logic i_wire_reset,
  painterengine_gpu_blitter_if.master bus
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] BLK = AW'(BLOCK_PIXELS);
  localparam logic [AW-1:0] BPP = AW'(BYTES_PER_PIXEL);

  typedef enum logic [7:0] {
    IDLE  = 8'h00,
    CALC  = 8'h01,
    READ1 = 8'h02,
    READ2 = 8'h03,
    WRITE = 8'h04,
    DONE  = 8'h05,
    ERROR = 8'h06
  } state_t;

  state_t state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [AW-1:0] sw_q, sw_d, dw_q, dw_d;
  logic [AW-1:0] xc_q, xc_d, yc_q, yc_d;
  logic [AW-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0] ra_q, ra_d, rl_q, rl_d;
  logic [AW-1:0] wa_q, wa_d, wl_q, wl_d;
  logic r1_q, r1_d, r2_q, r2_d, w_q, w_d;
  logic fifo_q, fifo_d;

  logic [AW-1:0] rem, len, src_addr, dst_addr;

  assign rem = xc_q - x_q;
  assign len = (rem > BLK) ? BLK : rem;
  assign src_addr = src_q + (y_q * sw_q + x_q) * BPP;
  assign dst_addr = dst_q + (y_q * dw_q + x_q) * BPP;

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q <= IDLE;
      mode_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      sw_q    <= '0;
      dw_q    <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ra_q    <= '0;
      rl_q    <= '0;
      wa_q    <= '0;
      wl_q    <= '0;
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      w_q     <= 1'b0;
      fifo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      sw_q    <= sw_d;
      dw_q    <= dw_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ra_q    <= ra_d;
      rl_q    <= rl_d;
      wa_q    <= wa_d;
      wl_q    <= wl_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      w_q     <= w_d;
      fifo_q  <= fifo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    sw_d    = sw_q;
    dw_d    = dw_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    x_d     = x_q;
    y_d     = y_q;
    ra_d    = ra_q;
    rl_d    = rl_q;
    wa_d    = wa_q;
    wl_d    = wl_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    w_d     = w_q;
    fifo_d  = fifo_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.i_wire_start) begin
          mode_d = bus.i_wire_mode;
          src_d  = bus.i_wire_src_frame_buffer_address;
          dst_d  = bus.i_wire_dst_frame_buffer_address;
          sw_d   = bus.i_wire_src_frame_buffer_width;
          dw_d   = bus.i_wire_dst_frame_buffer_width;
          xc_d   = bus.i_wire_render_frame_buffer_xcount;
          yc_d   = bus.i_wire_render_frame_buffer_ycount;
          x_d    = '0;
          y_d    = '0;
          fifo_d = 1'b1;
          if (bus.i_wire_mode == 2'b11)
            state_d = ERROR;
          else if (bus.i_wire_render_frame_buffer_xcount == '0 ||
                   bus.i_wire_render_frame_buffer_ycount == '0)
            state_d = DONE;
          else
            state_d = CALC;
        end
      end
      CALC: begin
        if (x_q == xc_q) begin
          if (y_q + AW'(1) == yc_q) begin
            state_d = DONE;
          end else begin
            x_d = '0;
            y_d = y_q + AW'(1);
          end
        end else if (mode_q == 2'b10) begin
          wa_d    = dst_addr;
          wl_d    = len;
          w_d     = 1'b1;
          state_d = WRITE;
        end else begin
          ra_d    = src_addr;
          rl_d    = len;
          r1_d    = 1'b1;
          state_d = READ1;
        end
      end
      READ1: begin
        if (bus.i_wire_reader_error) begin
          r1_d    = 1'b0;
          state_d = ERROR;
        end else if (bus.i_wire_reader_done) begin
          r1_d = 1'b0;
          if (mode_q == 2'b01) begin
            ra_d    = dst_addr;
            r2_d    = 1'b1;
            state_d = READ2;
          end else begin
            wa_d    = dst_addr;
            wl_d    = len;
            w_d     = 1'b1;
            state_d = WRITE;
          end
        end
      end
      READ2: begin
        if (bus.i_wire_reader_error) begin
          r2_d    = 1'b0;
          state_d = ERROR;
        end else if (bus.i_wire_reader_done) begin
          r2_d    = 1'b0;
          wa_d    = dst_addr;
          wl_d    = len;
          w_d     = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.i_wire_writer_error) begin
          w_d     = 1'b0;
          state_d = ERROR;
        end else if (bus.i_wire_writer_done) begin
          w_d     = 1'b0;
          x_d     = x_q + len;
          state_d = CALC;
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_wire_reader_address = ra_q;
  assign bus.o_wire_reader_length  = rl_q;
  assign bus.o_wire_reader1_resetn = r1_q;
  assign bus.o_wire_reader2_resetn = r2_q;
  assign bus.o_wire_writer_address = wa_q;
  assign bus.o_wire_writer_length  = wl_q;
  assign bus.o_wire_writer_resetn  = w_q;
  assign bus.o_wire_fifo1_resetn   = fifo_q;
  assign bus.o_wire_fifo2_resetn   = fifo_q;
  assign bus.o_wire_done  = (state_q == DONE);
  assign bus.o_wire_error = (state_q == ERROR);
  assign bus.o_wire_busy  = !(state_q == IDLE ||
                              state_q == DONE ||
                              state_q == ERROR);
  assign bus.o_wire_state = {24'h0, state_q};
endmodule

// File: tb/tb_painterengine_gpu_blitter.sv
// Scoreboard bench for the region blitter with a simple
// reader/writer responder.
module tb_painterengine_gpu_blitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  painterengine_gpu_blitter_if #(.ADDR_WIDTH(32)) bus ();

  painterengine_gpu_blitter #(
    .BLOCK_PIXELS(8),
    .ADDR_WIDTH(32),
    .BYTES_PER_PIXEL(4)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_reset(rst),
    .bus(bus.master)
  );

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] len;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] st_log[$];
  int total = 0;
  int bad = 0;
  int n_wr = 0;
  int n_rd = 0;
  int overlap = 0;
  bit err_inj = 1'b0;
  int c1 = 0, c2 = 0, cw = 0;
  logic p1 = 1'b0, p2 = 1'b0, pw = 1'b0;
  logic [7:0] pst = 8'h00;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic observe(int kind, logic [31:0] a,
                         logic [31:0] l);
    txn_t e;
    if (kind == 3) n_wr++;
    else n_rd++;
    if (exp_q.size() == 0) begin
      check("extra_txn", 64'(kind), 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("txn_kind", 64'(kind), 64'(e.kind));
      check("txn_addr", 64'(a), 64'(e.addr));
      check("txn_len", 64'(l), 64'(e.len));
    end
  endtask

  // responder: done pulse on the third cycle of each enable
  always @(negedge clk) begin
    bus.i_wire_reader_done  = 1'b0;
    bus.i_wire_reader_error = 1'b0;
    bus.i_wire_writer_done  = 1'b0;
    bus.i_wire_writer_error = 1'b0;
    if (bus.o_wire_reader1_resetn && c1 == 2) begin
      bus.i_wire_reader_done  = 1'b1;
      bus.i_wire_reader_error = err_inj;
    end
    if (bus.o_wire_reader2_resetn && c2 == 2)
      bus.i_wire_reader_done = 1'b1;
    if (bus.o_wire_writer_resetn && cw == 2)
      bus.i_wire_writer_done = 1'b1;
    c1 = bus.o_wire_reader1_resetn ? c1 + 1 : 0;
    c2 = bus.o_wire_reader2_resetn ? c2 + 1 : 0;
    cw = bus.o_wire_writer_resetn ? cw + 1 : 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(bus.o_wire_reader1_resetn) +
          int'(bus.o_wire_reader2_resetn) +
          int'(bus.o_wire_writer_resetn) > 1)
        overlap++;
      if (bus.o_wire_reader1_resetn && !p1)
        observe(1, bus.o_wire_reader_address,
                bus.o_wire_reader_length);
      if (bus.o_wire_reader2_resetn && !p2)
        observe(2, bus.o_wire_reader_address,
                bus.o_wire_reader_length);
      if (bus.o_wire_writer_resetn && !pw)
        observe(3, bus.o_wire_writer_address,
                bus.o_wire_writer_length);
      if (bus.o_wire_state[7:0] != pst)
        st_log.push_back(bus.o_wire_state[7:0]);
    end
    p1  = bus.o_wire_reader1_resetn;
    p2  = bus.o_wire_reader2_resetn;
    pw  = bus.o_wire_writer_resetn;
    pst = bus.o_wire_state[7:0];
  end

  task automatic push_op(int mode, logic [31:0] src,
                         logic [31:0] dst, logic [31:0] sw,
                         logic [31:0] dw, logic [31:0] xc,
                         logic [31:0] yc);
    logic [31:0] l;
    for (logic [31:0] y = 0; y < yc; y++) begin
      for (logic [31:0] x = 0; x < xc; x += l) begin
        l = (xc - x > 8) ? 32'd8 : xc - x;
        if (mode != 2)
          exp_q.push_back('{1, src + (y * sw + x) * 4, l});
        if (mode == 1)
          exp_q.push_back('{2, dst + (y * dw + x) * 4, l});
        exp_q.push_back('{3, dst + (y * dw + x) * 4, l});
      end
    end
  endtask

  task automatic set_cfg(int mode, logic [31:0] src,
                         logic [31:0] dst, logic [31:0] sw,
                         logic [31:0] dw, logic [31:0] xc,
                         logic [31:0] yc);
    bus.i_wire_mode = 2'(mode);
    bus.i_wire_src_frame_buffer_address = src;
    bus.i_wire_dst_frame_buffer_address = dst;
    bus.i_wire_src_frame_buffer_width = sw;
    bus.i_wire_dst_frame_buffer_width = dw;
    bus.i_wire_render_frame_buffer_xcount = xc;
    bus.i_wire_render_frame_buffer_ycount = yc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_wire_start = 1'b1;
    @(negedge clk);
    bus.i_wire_start = 1'b0;
  endtask

  task automatic wait_end(string tag);
    int n = 0;
    while (!(bus.o_wire_done || bus.o_wire_error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    @(negedge clk);
  endtask

  task automatic run_op(string tag, int mode, logic [31:0] src,
                        logic [31:0] dst, logic [31:0] sw,
                        logic [31:0] dw, logic [31:0] xc,
                        logic [31:0] yc);
    n_wr = 0;
    n_rd = 0;
    set_cfg(mode, src, dst, sw, dw, xc, yc);
    push_op(mode, src, dst, sw, dw, xc, yc);
    pulse_start();
    wait_end(tag);
    check({tag, "_done"}, 64'(bus.o_wire_done), 64'd1);
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bus.i_wire_start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_state", 64'(bus.o_wire_state), 64'd0);
    check("rst_flags", 64'({bus.o_wire_busy, bus.o_wire_done,
          bus.o_wire_error}), 64'd0);
    check("rst_en", 64'({bus.o_wire_reader1_resetn,
          bus.o_wire_reader2_resetn, bus.o_wire_writer_resetn,
          bus.o_wire_fifo1_resetn, bus.o_wire_fifo2_resetn}), 64'd0);
    check("rst_addr", 64'({bus.o_wire_reader_address,
          bus.o_wire_writer_length}), 64'd0);
    rst = 1'b0;

    run_op("copy", 0, 32'h1000, 32'h8000, 32, 32, 20, 2);
    check("copy_writes", 64'(n_wr), 64'd6);
    check("copy_fifo", 64'({bus.o_wire_fifo1_resetn,
          bus.o_wire_fifo2_resetn}), 64'd3);

    st_log.delete();
    run_op("blend", 1, 32'h2000, 32'h9000, 64, 16, 5, 1);
    check("blend_nst", 64'(st_log.size()), 64'd6);
    if (st_log.size() == 6) begin
      logic [7:0] seq [6] = '{1, 2, 3, 4, 1, 5};
      for (int i = 0; i < 6; i++)
        check("blend_seq", 64'(st_log[i]), 64'(seq[i]));
    end

    run_op("fill", 2, 32'h100, 32'h4000, 100, 40, 9, 3);
    check("fill_reads", 64'(n_rd), 64'd0);
    check("fill_writes", 64'(n_wr), 64'd6);

    n_rd = 0;
    n_wr = 0;
    set_cfg(0, 32'h10, 32'h20, 4, 4, 0, 5);
    pulse_start();
    check("zx_done", 64'(bus.o_wire_done), 64'd1);
    check("zx_state", 64'(bus.o_wire_state), 64'd5);
    set_cfg(1, 32'h10, 32'h20, 4, 4, 7, 0);
    pulse_start();
    check("zy_done", 64'(bus.o_wire_done), 64'd1);
    repeat (2) @(negedge clk);
    check("zero_txns", 64'(n_rd + n_wr), 64'd0);

    n_wr = 0;
    set_cfg(0, 32'h3000, 32'h5000, 16, 16, 16, 1);
    push_op(0, 32'h3000, 32'h5000, 16, 16, 16, 1);
    pulse_start();
    bus.i_wire_render_frame_buffer_xcount = 4;
    wait_end("cfgchg");
    check("cfgchg_writes", 64'(n_wr), 64'd2);
    check("cfgchg_left", 64'(exp_q.size()), 64'd0);

    check("overlap", 64'(overlap), 64'd0);

    err_inj = 1'b1;
    set_cfg(0, 32'h700, 32'h900, 8, 8, 8, 1);
    exp_q.push_back('{1, 32'h700, 32'd8});
    pulse_start();
    wait_end("rderr");
    err_inj = 1'b0;
    check("rderr_err", 64'(bus.o_wire_error), 64'd1);
    check("rderr_state", 64'(bus.o_wire_state), 64'd6);
    check("rderr_busy", 64'(bus.o_wire_busy), 64'd0);
    check("rderr_r1", 64'(bus.o_wire_reader1_resetn), 64'd0);
    pulse_start();
    check("rderr_sticky", 64'(bus.o_wire_state), 64'd6);
    do_reset();
    check("rderr_rst", 64'(bus.o_wire_state), 64'd0);

    set_cfg(0, 32'h1000, 32'h8000, 32, 32, 20, 1);
    push_op(0, 32'h1000, 32'h8000, 32, 32, 20, 1);
    pulse_start();
    n = 0;
    while (bus.o_wire_state != 32'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midw_reach", 64'(bus.o_wire_state), 64'd4);
    rst = 1'b1;
    #1;
    check("midw_state", 64'(bus.o_wire_state), 64'd0);
    check("midw_en", 64'({bus.o_wire_writer_resetn,
          bus.o_wire_reader1_resetn, bus.o_wire_fifo1_resetn,
          bus.o_wire_fifo2_resetn, bus.o_wire_busy}), 64'd0);
    check("midw_addr", 64'(bus.o_wire_writer_address), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    set_cfg(3, 32'h10, 32'h20, 4, 4, 4, 4);
    pulse_start();
    check("m11_err", 64'(bus.o_wire_error), 64'd1);
    check("m11_state", 64'(bus.o_wire_state), 64'd6);
    set_cfg(0, 32'h10, 32'h20, 4, 4, 4, 4);
    pulse_start();
    @(negedge clk);
    check("m11_sticky", 64'(bus.o_wire_state), 64'd6);
    check("m11_noen", 64'(bus.o_wire_reader1_resetn), 64'd0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
